// File: rtl/arbitro_bus_rtc.sv
// Arbiter/sequencer for the shared RTC bus: runs init once, then grants periodic reads
// and user writes, muxing the granted sub-FSM onto the bus pins under a watchdog.
module arbitro_bus_rtc #(
  parameter int unsigned REFRESH_CYCLES = 1000,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_escribir,
  input  logic       fin_inicializar,
  input  logic       fin_leer,
  input  logic       fin_escribir,
  input  logic [3:0] bus_ini,
  input  logic [3:0] bus_leer,
  input  logic [3:0] bus_esc,
  output logic       do_it_inicializar,
  output logic       do_it_leer,
  output logic       do_it_escribir,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [1:0] grant,
  output logic       ocupado,
  output logic       timeout_err
);

  localparam int unsigned RefW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned WdW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_CYCLES - 1);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StArranque, StIni, StIdle, StLeer, StEsc} state_e;

  state_e          state_q, state_d;
  logic [RefW-1:0] refresh_q, refresh_d;
  logic [WdW-1:0]  wdog_q, wdog_d;
  logic            esc_pend_q, esc_pend_d;
  logic            leer_pend_q, leer_pend_d;
  logic            fin_cur, fin_ok, forced, entering;
  logic            do_ini_d, do_leer_d, do_esc_d, ocupado_d, timeout_err_d;
  logic [1:0]      grant_d;
  logic [3:0]      bus_mux;

  // State register plus all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= StArranque;
      refresh_q         <= '0;
      wdog_q            <= '0;
      esc_pend_q        <= 1'b0;
      leer_pend_q       <= 1'b0;
      do_it_inicializar <= 1'b0;
      do_it_leer        <= 1'b0;
      do_it_escribir    <= 1'b0;
      grant             <= 2'b00;
      ocupado           <= 1'b1;
      timeout_err       <= 1'b0;
    end else begin
      state_q           <= state_d;
      refresh_q         <= refresh_d;
      wdog_q            <= wdog_d;
      esc_pend_q        <= esc_pend_d;
      leer_pend_q       <= leer_pend_d;
      do_it_inicializar <= do_ini_d;
      do_it_leer        <= do_leer_d;
      do_it_escribir    <= do_esc_d;
      grant             <= grant_d;
      ocupado           <= ocupado_d;
      timeout_err       <= timeout_err_d;
    end
  end

  // Next-state: only the granted FSM's fin counts; fin beats a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    fin_cur = 1'b0;
    fin_ok  = 1'b0;
    forced  = 1'b0;
    case (state_q)
      StIni:   fin_cur = fin_inicializar;
      StLeer:  fin_cur = fin_leer;
      StEsc:   fin_cur = fin_escribir;
      default: fin_cur = 1'b0;
    endcase
    case (state_q)
      StArranque: state_d = StIni;
      StIdle: begin
        if (esc_pend_q) begin
          state_d = StEsc;
        end else if (leer_pend_q) begin
          state_d = StLeer;
        end
      end
      StIni, StLeer, StEsc: begin
        if (fin_cur) begin
          state_d = StIdle;
          fin_ok  = 1'b1;
        end else if (wdog_q == WdLast) begin
          state_d = StIdle;
          forced  = 1'b1;
        end
      end
      default: state_d = StArranque;
    endcase
  end

  // Counters and pending flags; a new request in the grant cycle stays pending.
  always_comb begin
    entering  = (state_d != state_q);
    wdog_d    = '0;
    refresh_d = '0;
    if (!entering && (state_q inside {StIni, StLeer, StEsc})) begin
      wdog_d = wdog_q + 1'b1;
    end
    if (state_q != StArranque && refresh_q != RefLast) begin
      refresh_d = refresh_q + 1'b1;
    end
    esc_pend_d  = (esc_pend_q && !(state_q == StIdle && state_d == StEsc)) ||
                  (req_escribir && state_q != StArranque);
    leer_pend_d = (leer_pend_q && !(state_q == StIdle && state_d == StLeer)) ||
                  (refresh_q == RefLast && state_q != StArranque);
  end

  // Registered outputs decoded from the upcoming state.
  always_comb begin
    do_ini_d  = entering && (state_d == StIni);
    do_leer_d = entering && (state_d == StLeer);
    do_esc_d  = entering && (state_d == StEsc);
    ocupado_d = (state_d != StIdle);
    case (state_d)
      StIni:   grant_d = 2'b01;
      StLeer:  grant_d = 2'b10;
      StEsc:   grant_d = 2'b11;
      default: grant_d = 2'b00;
    endcase
    timeout_err_d = timeout_err;
    if (forced) begin
      timeout_err_d = 1'b1;
    end else if (fin_ok) begin
      timeout_err_d = 1'b0;
    end
  end

  // Zero-latency pin mux selected by the registered state.
  always_comb begin
    case (state_q)
      StIni:   bus_mux = bus_ini;
      StLeer:  bus_mux = bus_leer;
      StEsc:   bus_mux = bus_esc;
      default: bus_mux = 4'b1111;
    endcase
    {a_d, cs, rd, wr} = bus_mux;
  end

endmodule

// File: tb/tb_arbitro_bus_rtc.sv
// Directed bench for arbitro_bus_rtc: init, periodic reads, write priority,
// watchdog timeout and mid-transaction reset, all with hand-computed timing.
module tb_arbitro_bus_rtc;

  logic       clk;
  logic       reset;
  logic       req_escribir;
  logic       fin_inicializar, fin_leer, fin_escribir;
  logic [3:0] bus_ini, bus_leer, bus_esc;
  logic       do_it_inicializar, do_it_leer, do_it_escribir;
  logic       a_d, cs, rd, wr;
  logic [1:0] grant;
  logic       ocupado, timeout_err;
  logic [3:0] pins;

  int n_checks = 0;
  int n_pass   = 0;
  int waited;

  arbitro_bus_rtc #(
    .REFRESH_CYCLES(50),
    .TIMEOUT       (20)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req_escribir     (req_escribir),
    .fin_inicializar  (fin_inicializar),
    .fin_leer         (fin_leer),
    .fin_escribir     (fin_escribir),
    .bus_ini          (bus_ini),
    .bus_leer         (bus_leer),
    .bus_esc          (bus_esc),
    .do_it_inicializar(do_it_inicializar),
    .do_it_leer       (do_it_leer),
    .do_it_escribir   (do_it_escribir),
    .a_d              (a_d),
    .cs               (cs),
    .rd               (rd),
    .wr               (wr),
    .grant            (grant),
    .ocupado          (ocupado),
    .timeout_err      (timeout_err)
  );

  assign pins = {a_d, cs, rd, wr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges; samples are taken 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_do_leer(input int budget, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!do_it_leer && n < budget);
  endtask

  initial begin
    reset = 1'b1;
    req_escribir = 1'b0;
    fin_inicializar = 1'b0;
    fin_leer = 1'b0;
    fin_escribir = 1'b0;
    bus_ini  = 4'b1010;
    bus_leer = 4'b0110;
    bus_esc  = 4'b0011;

    // Reset state
    tick(10);
    check("rst_grant", grant, 2'b00);
    check("rst_ocupado", ocupado, 1'b1);
    check("rst_bus", pins, 4'b1111);
    check("rst_do_it", {do_it_inicializar, do_it_leer, do_it_escribir}, 3'b000);
    check("rst_terr", timeout_err, 1'b0);

    // Init: first edge after release enters INI with a one-cycle start pulse (E1)
    reset = 1'b0;
    tick(1);
    check("ini_do_it", do_it_inicializar, 1'b1);
    check("ini_grant", grant, 2'b01);
    check("ini_bus", pins, 4'b1010);
    tick(1);
    check("ini_pulse_1cyc", do_it_inicializar, 1'b0);
    tick(8);
    fin_inicializar = 1'b1;
    tick(1);                                // E11
    fin_inicializar = 1'b0;
    check("ini_done_grant", grant, 2'b00);
    check("ini_done_bus", pins, 4'b1111);
    check("ini_done_ocupado", ocupado, 1'b0);

    // Periodic reads: leer_pend sets at E51, LEER at E52, next at E102
    wait_do_leer(200, waited);
    check("leer1_latency", waited, 8'd41);
    check("leer1_grant", grant, 2'b10);
    check("leer1_bus", pins, 4'b0110);
    tick(9);
    fin_leer = 1'b1;
    tick(1);                                // E62
    fin_leer = 1'b0;
    check("leer1_done_grant", grant, 2'b00);
    check("leer1_done_bus", pins, 4'b1111);
    wait_do_leer(200, waited);              // E102
    check("leer2_period", waited, 8'd40);
    tick(9);
    fin_leer = 1'b1;
    tick(1);                                // E112
    fin_leer = 1'b0;
    check("leer2_done_grant", grant, 2'b00);

    // Write request in the same cycle the refresh wraps (E151): write first
    tick(38);
    req_escribir = 1'b1;
    tick(1);                                // E151
    req_escribir = 1'b0;
    check("both_pend_idle", grant, 2'b00);
    tick(1);                                // E152
    check("esc_first_grant", grant, 2'b11);
    check("esc_first_do_it", {do_it_escribir, do_it_leer}, 2'b10);
    check("esc_bus", pins, 4'b0011);
    tick(4);
    fin_escribir = 1'b1;
    tick(1);                                // E157
    fin_escribir = 1'b0;
    check("gap_grant", grant, 2'b00);
    check("gap_bus", pins, 4'b1111);
    check("gap_no_start", do_it_leer, 1'b0);
    tick(1);                                // E158
    check("leer_after_esc", {grant, do_it_leer}, 3'b101);

    // Read without fin: forced release after exactly 20 cycles (E178)
    tick(19);
    check("wd_still_granted", grant, 2'b10);
    tick(1);
    check("wd_grant", grant, 2'b00);
    check("wd_terr", timeout_err, 1'b1);
    check("wd_bus", pins, 4'b1111);
    wait_do_leer(200, waited);              // E202
    check("leer3_latency", waited, 8'd24);
    check("terr_sticky", timeout_err, 1'b1);
    tick(9);
    fin_leer = 1'b1;
    tick(1);                                // E212
    fin_leer = 1'b0;
    check("terr_cleared", timeout_err, 1'b0);

    // Reset in the middle of a write; pending write dropped, init rerun
    req_escribir = 1'b1;
    tick(1);                                // E213
    req_escribir = 1'b0;
    tick(1);                                // E214
    check("esc2_start", {grant, do_it_escribir}, 3'b111);
    tick(1);
    req_escribir = 1'b1;
    tick(1);
    req_escribir = 1'b0;
    tick(1);                                // E217
    reset = 1'b1;
    tick(1);                                // E218
    check("midrst_grant", grant, 2'b00);
    check("midrst_bus", pins, 4'b1111);
    check("midrst_ocupado", ocupado, 1'b1);
    reset = 1'b0;
    tick(1);                                // E219
    check("reini_start", {grant, do_it_inicializar}, 3'b011);
    check("reini_bus", pins, 4'b1010);
    fin_escribir = 1'b1;
    tick(1);
    fin_escribir = 1'b0;
    check("stray_fin_ignored", grant, 2'b01);
    tick(3);
    fin_inicializar = 1'b1;
    tick(1);                                // E224
    fin_inicializar = 1'b0;
    check("reini_done", {grant, ocupado}, 3'b000);
    tick(1);
    check("esc_pend_dropped", grant, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
